// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial receiver with 16x oversampling, majority-vote bit
// decisions, and a first-word fall-through receive FIFO with a sticky
// overrun flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, prescaler held at 0, waiting for rxS=0
// START     | qualifying the start bit (majority at tick 9)
// DATA      | sampling 8 data bits, LSB first
// STOP      | checking the stop bit; push or frame error at tick 9
// WAIT_HIGH | after a framing error, waiting for the line to return high
module rx_uart #(
  parameter int TICK_DIV   = 325,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rxData,
  input  logic                         readEn,
  input  logic                         clrErr,
  output logic [7:0]                   dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  rdDataCount,
  output logic                         frameErr,
  output logic                         overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      tidx_q, tidx_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;

  logic rx_s, tick, mid_tick, end_tick, maj, push, pop, wr_en;

  assign rx_s     = sync_q[1];
  assign tick     = (state_q != S_IDLE) && (presc_q == PRESC_MAX);
  assign mid_tick = tick && (tidx_q == 4'd9);
  assign end_tick = tick && (tidx_q == 4'd15);
  // samp_q holds the tick-7 and tick-8 samples; the live value is the tick-9 sample
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // State and datapath registers; synchronizer resets to the idle-high level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      presc_q   <= '0;
      tidx_q    <= '0;
      bitcnt_q  <= '0;
      data_q    <= '0;
      samp_q    <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      presc_q   <= presc_d;
      tidx_q    <= tidx_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      samp_q    <= samp_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic of the frame FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s) state_d = S_START;
      S_START: begin
        if (mid_tick && maj) state_d = S_IDLE;
        else if (end_tick)   state_d = S_DATA;
      end
      S_DATA:      if (end_tick && (bitcnt_q == 3'd7)) state_d = S_STOP;
      S_STOP:      if (mid_tick) state_d = maj ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs: push a good byte or flag a bad stop bit, both at tick 9 of STOP
  always_comb begin
    push     = 1'b0;
    frameErr = 1'b0;
    if (state_q == S_STOP && mid_tick) begin
      push     = maj;
      frameErr = !maj;
    end
  end

  // Synchronizer, oversample timing and data shift register
  always_comb begin
    sync_d   = {sync_q[0], rxData};
    presc_d  = presc_q;
    tidx_d   = tidx_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    samp_d   = samp_q;
    if (state_q == S_IDLE) begin
      // leaving IDLE therefore always enters START with fresh counters
      presc_d  = '0;
      tidx_d   = '0;
      bitcnt_d = '0;
    end else begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      if (tick) begin
        tidx_d = tidx_q + 4'd1;
        if (tidx_q == 4'd7) samp_d[0] = rx_s;
        if (tidx_q == 4'd8) samp_d[1] = rx_s;
      end
      if (state_q == S_DATA && mid_tick) data_d = {maj, data_q[7:1]};
      if (state_q == S_DATA && end_tick) bitcnt_d = bitcnt_q + 3'd1;
    end
  end

  // Receive FIFO: simultaneous push and pop always both succeed, even when full
  always_comb begin
    pop       = readEn && (count_q != '0);
    wr_en     = push && ((count_q != DEPTH_C) || pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d   = count_q + CW'(wr_en) - CW'(pop);
    overrun_d = overrun_q;
    if (push && !wr_en) overrun_d = 1'b1;
    else if (clrErr)    overrun_d = 1'b0;
  end

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign rdDataCount = count_q;
  assign dout        = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_rx_uart.sv
// Testbench for rx_uart at TICK_DIV=4 (64 clk per bit) and FIFO_DEPTH=4.
module tb_rx_uart;
  localparam int TICK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT        = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxData = 1'b1;
  logic       readEn = 1'b0;
  logic       clrErr = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frameErr, overrun;
  logic [2:0] rdDataCount;

  int checks = 0;
  int errors = 0;
  int fe_count = 0;
  int empty_falls = 0;
  logic prev_empty = 1'b1;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  rx_uart #(.TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .readEn(readEn), .clrErr(clrErr),
    .dout(dout), .empty(empty), .full(full), .rdDataCount(rdDataCount),
    .frameErr(frameErr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameErr === 1'b1) fe_count++;
    if (prev_empty === 1'b1 && empty === 1'b0) empty_falls++;
    prev_empty = empty;
  end

  // drives one frame starting at the current negedge; stop bit held stop_len clk
  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_lvl);
    rxData = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxData = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxData = stop_lvl;
    repeat (stop_len) @(negedge clk);
    rxData = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (rdDataCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rdDataCount); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (overrun !== 1'b0 || frameErr !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovr=%b fe=%b expected 0 0", overrun, frameErr); end
  endtask

  task automatic test_single();
    int fe0, falls0, t;
    fe0 = fe_count; falls0 = empty_falls; t = -1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, BIT, 1'b1);
      for (int i = 1; i <= 10 * BIT; i++) begin
        @(negedge clk);
        if (t < 0 && empty === 1'b0) t = i;
      end
    join
    checks++; if (t < 600 || t > 620) begin errors++; $display("FAIL single_latency: got %0d clk expected 600..620", t); end
    checks++; if (empty_falls - falls0 != 1) begin errors++; $display("FAIL single_falls: got %0d expected 1", empty_falls - falls0); end
    checks++; if (fe_count != fe0) begin errors++; $display("FAIL single_frameerr: got %0d pulses expected 0", fe_count - fe0); end
    exp_b = exp_q.pop_front();
    checks++; if (dout !== exp_b) begin errors++; $display("FAIL single_dout: got %h expected %h", dout, exp_b); end
    readEn = 1'b1; @(negedge clk); readEn = 1'b0;
    checks++; if (empty !== 1'b1 || rdDataCount !== 3'd0) begin errors++; $display("FAIL single_pop: got empty=%b cnt=%0d expected 1 0", empty, rdDataCount); end
  endtask

  task automatic test_read_empty();
    readEn = 1'b1; @(negedge clk); readEn = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || rdDataCount !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL read_empty: got empty=%b cnt=%0d full=%b expected 1 0 0", empty, rdDataCount, full); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_count;
    send_frame(8'h3C, 200, 1'b0);
    repeat (16) @(negedge clk);
    checks++; if (fe_count - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_count - fe0); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ferr_empty: got %b expected 1", empty); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, BIT, 1'b1);
    exp_b = exp_q.pop_front();
    checks++; if (empty !== 1'b0 || dout !== exp_b) begin errors++; $display("FAIL ferr_next: got empty=%b dout=%h expected 0 %h", empty, dout, exp_b); end
    readEn = 1'b1; @(negedge clk); readEn = 1'b0;
    checks++; if (fe_count - fe0 != 1) begin errors++; $display("FAIL ferr_total: got %0d expected 1", fe_count - fe0); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_count;
    rxData = 1'b0;
    repeat (20) @(negedge clk);
    rxData = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (empty !== 1'b1 || fe_count != fe0) begin errors++; $display("FAIL glitch_quiet: got empty=%b fe=%0d expected 1 0", empty, fe_count - fe0); end
    exp_q.push_back(8'h96);
    send_frame(8'h96, BIT, 1'b1);
    exp_b = exp_q.pop_front();
    checks++; if (empty !== 1'b0 || dout !== exp_b) begin errors++; $display("FAIL glitch_next: got empty=%b dout=%h expected 0 %h", empty, dout, exp_b); end
    readEn = 1'b1; @(negedge clk); readEn = 1'b0;
  endtask

  task automatic test_overrun();
    logic exp_ovr;
    exp_ovr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(8'(i));
      else exp_ovr = 1'b1;
      send_frame(8'(i), BIT, 1'b1);
      if (i == 4) begin
        checks++; if (full !== 1'b1 || rdDataCount !== 3'd4 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_full4: got full=%b cnt=%0d ovr=%b expected 1 4 0", full, rdDataCount, overrun); end
      end
    end
    checks++; if (overrun !== exp_ovr || rdDataCount !== 3'd4) begin errors++; $display("FAIL ovr_set: got ovr=%b cnt=%0d expected %b 4", overrun, rdDataCount, exp_ovr); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_b = exp_q.pop_front();
      checks++; if (dout !== exp_b || empty !== 1'b0) begin errors++; $display("FAIL ovr_pop%0d: got %h empty=%b expected %h", i, dout, empty, exp_b); end
      readEn = 1'b1; @(negedge clk); readEn = 1'b0;
    end
    checks++; if (empty !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_drained: got empty=%b ovr=%b expected 1 1", empty, overrun); end
    clrErr = 1'b1; @(negedge clk); clrErr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_frame(8'h11 + 8'(i), BIT, 1'b1);
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ppf_full: got %b expected 1", full); end
    fork
      send_frame(8'h15, BIT, 1'b1);
      begin
        // readEn lands on the clk where the stop-bit decision pushes 0x15
        repeat (618) @(negedge clk);
        exp_b = exp_q.pop_front();
        checks++; if (dout !== exp_b) begin errors++; $display("FAIL ppf_head: got %h expected %h", dout, exp_b); end
        exp_q.push_back(8'h15);
        readEn = 1'b1; @(negedge clk); readEn = 1'b0;
      end
    join
    checks++; if (rdDataCount !== 3'd4 || overrun !== 1'b0) begin errors++; $display("FAIL ppf_count: got cnt=%0d ovr=%b expected 4 0", rdDataCount, overrun); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_b = exp_q.pop_front();
      checks++; if (dout !== exp_b) begin errors++; $display("FAIL ppf_pop%0d: got %h expected %h", i, dout, exp_b); end
      readEn = 1'b1; @(negedge clk); readEn = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    int fe0;
    exp_q.push_back(8'h77);
    send_frame(8'h77, BIT, 1'b1);
    checks++; if (rdDataCount !== 3'd1) begin errors++; $display("FAIL rmid_pre: got %0d expected 1", rdDataCount); end
    fe0 = fe_count;
    fork
      send_frame(8'hF3, BIT, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        exp_q.delete();
        checks++; if (empty !== 1'b1 || full !== 1'b0 || rdDataCount !== 3'd0 || dout !== 8'h00 || overrun !== 1'b0 || frameErr !== 1'b0) begin
          errors++; $display("FAIL rmid_outputs: got empty=%b full=%b cnt=%0d dout=%h ovr=%b fe=%b expected 1 0 0 00 0 0", empty, full, rdDataCount, dout, overrun, frameErr);
        end
      end
    join
    repeat (BIT) @(negedge clk);
    checks++; if (empty !== 1'b1 || fe_count != fe0) begin errors++; $display("FAIL rmid_nopush: got empty=%b fe=%0d expected 1 0", empty, fe_count - fe0); end
    exp_q.push_back(8'h6B);
    send_frame(8'h6B, BIT, 1'b1);
    exp_b = exp_q.pop_front();
    checks++; if (empty !== 1'b0 || dout !== exp_b || rdDataCount !== 3'd1) begin errors++; $display("FAIL rmid_next: got dout=%h cnt=%0d expected %h 1", dout, rdDataCount, exp_b); end
    readEn = 1'b1; @(negedge clk); readEn = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    repeat (4) @(negedge clk);
    test_single();
    test_read_empty();
    test_frame_err();
    repeat (8) @(negedge clk);
    test_glitch();
    test_overrun();
    test_push_pop_full();
    test_reset_midframe();
    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_uart.md
RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 SHALL have parameter TICK_DIV, default 325, giving clk cycles per 1/16-bit oversample tick (50 MHz / (9600*16), truncated).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, a power of two, giving the number of received-byte entries.
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port rxData  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 SHALL have port readEn  input  1  pops the head byte when the FIFO is not empty.
REQ-007 SHALL have port clrErr  input  1  clears the sticky overrun flag.
REQ-008 SHALL have port dout  output  8  head byte; first-word fall-through; valid while empty=0.
REQ-009 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-010 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port rdDataCount  output  log2(FIFO_DEPTH)+1  number of bytes held.
REQ-012 SHALL have port frameErr  output  1  one-clk pulse when a frame is rejected at stop bit.
REQ-013 SHALL have port overrun  output  1  sticky; a byte was dropped because the FIFO was full.

Function
REQ-014 SHALL pass rxData through a 2-flop synchronizer; all decisions use the synchronized value rxS.
REQ-015 SHALL hold the prescaler at 0 in IDLE; otherwise it counts 0..TICK_DIV-1 and emits a one-clk tick at TICK_DIV-1.
REQ-016 SHALL keep a 4-bit tick index (0..15) per bit period, reset to 0 on entry to START.
REQ-017 SHALL decide each bit as the majority of the rxS samples at tick indices 7, 8 and 9, evaluated on tick 9.
REQ-018 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-019 SHALL go IDLE -> START on the first clk where rxS=0.
REQ-020 SHALL, in START, go to IDLE on majority 1 (false start, nothing pushed) and otherwise to DATA at tick 15.
REQ-021 SHALL, in DATA, shift the majority into the data register LSB first, and after bit 7 at tick 15 go to STOP.
REQ-022 SHALL, in STOP, on majority 1 at tick 9, push the byte and go to IDLE in the same clk, with no wait for tick 15.
REQ-023 SHALL, in STOP, on majority 0, pulse frameErr for one clk, discard the byte and go to WAIT_HIGH.
REQ-024 SHALL leave WAIT_HIGH for IDLE only on the first clk with rxS=1.
REQ-025 SHALL make a pushed byte visible (empty=0, dout valid, count +1) on the clk after the push.
REQ-026 SHALL, for readEn with empty=0, advance the head next clk; readEn with empty=1 SHALL be ignored, with no underflow and no count change.
REQ-027 SHALL, when a push and a pop occur in the same clk (including when full), perform both; count is unchanged and overrun is not set.
REQ-028 SHALL, on a push with full=1 and no pop, drop the new byte, leave the FIFO unchanged and set overrun.
REQ-029 SHALL clear overrun on clrErr; if clrErr coincides with a new overrun event, overrun SHALL stay set.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with one extra count bit distinguishing full from empty.

Reset
REQ-031 SHALL, with rst_n=0 at a clk edge, set state to IDLE, clear prescaler, tick index, bit count and data register, and set the synchronizer flops to 1.
REQ-032 SHALL, under the same reset, empty the FIFO; outputs SHALL be dout=0, empty=1, full=0, rdDataCount=0, frameErr=0, overrun=0.
REQ-033 SHALL abort a frame in progress on reset mid-frame; the partial byte SHALL never be pushed, and after release the block SHALL wait for a fresh falling edge.

Verification (TICK_DIV=4, FIFO_DEPTH=4; bit period = 64 clk)
REQ-034 Send 0xA5 with a valid stop bit -> empty falls exactly once between 600 and 620 clk after the start edge, dout=0xA5, frameErr never pulses.
REQ-035 Send 0x3C with the stop bit held low until 200 clk later -> exactly one frameErr pulse and FIFO still empty; a following 0x5A is then received correctly.
REQ-036 Drive a 20-clk low glitch on idle rxData -> no push, no frameErr, and state back in IDLE before clk 60.
REQ-037 Send 0x01..0x05 back-to-back with no reads -> full=1 and rdDataCount=4 after byte 4, overrun=1 after byte 5, pops return 01,02,03,04; clrErr then clears overrun.
REQ-038 With the FIFO full, assert readEn on the clk of the next push -> count stays 4, overrun stays 0, new byte ends up at the tail.
REQ-039 Assert rst_n=0 for 1 clk in the middle of bit 4 of a frame -> all outputs return to reset values, and the remainder of that frame produces no push.
